// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store as two 16-bit SRAM transactions.
// Latency: ready low for 1+2*WAIT_CYCLES cycles from the request cycle, high in DONE.
// Backpressure: ready=0 freezes every upstream stage until the access reaches DONE.
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] mem_rd_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] st_val_q, st_val_d;
  logic [15:0] rd_lo_q, rd_lo_d;
  logic [31:0] rd_data_q, rd_data_d;

  // Only the low 19 bits of the offset matter: the word index is bits [18:2],
  // and truncating before the subtract gives the same wrapped result.
  logic [18:0] addr_off;
  logic        request;
  logic        last_cyc;
  logic        unused_bits;

  assign addr_off    = alu_res[18:0] - BASE_ADDR[18:0];
  assign request     = mem_r_en | mem_w_en;
  assign last_cyc    = (cnt_q == LAST_CNT);
  assign mem_rd_data = rd_data_q;
  assign unused_bits = ^{alu_res[31:19], addr_off[1:0]};

  // Next-state, latch and SRAM bus decode; idle bus values are the defaults.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    word_d      = word_q;
    st_val_d    = st_val_q;
    rd_lo_d     = rd_lo_q;
    rd_data_d   = rd_data_q;
    ready       = 1'b1;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~request;
        if (request) begin
          state_d  = LO;
          cnt_d    = 4'd0;
          wr_d     = mem_w_en;   // write wins when both enables are set
          word_d   = addr_off[18:2];
          st_val_d = st_val;
        end
      end
      LO: begin
        ready     = 1'b0;
        sram_addr = {word_q, 1'b0};
        if (wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = st_val_q[15:0];
          sram_we_n   = last_cyc;   // strobe released on the last cycle to hold data
        end
        if (last_cyc) begin
          state_d = HI;
          cnt_d   = 4'd0;
          if (!wr_q) rd_lo_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        ready     = 1'b0;
        sram_addr = {word_q, 1'b1};
        if (wr_q) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = st_val_q[31:16];
          sram_we_n   = last_cyc;
        end
        if (last_cyc) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          // High half goes straight into the result so it is visible in DONE.
          if (!wr_q) rd_data_d = {sram_dq_in, rd_lo_q};
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;   // the frozen request must not relaunch here
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      word_q    <= 17'd0;
      st_val_q  <= 32'd0;
      rd_lo_q   <= 16'd0;
      rd_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      word_q    <= word_d;
      st_val_q  <= st_val_d;
      rd_lo_q   <= rd_lo_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM.
// Inputs change 1ns after posedge; outputs are checked at negedge.
// Every access is tracked cycle by cycle against hand-computed bus values.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] alu_res;
  logic [31:0] st_val;
  logic        ready;
  logic [31:0] mem_rd_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_vec;
  int n_err;

  logic [15:0] sram_mem [0:15];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .alu_res     (alu_res),
    .st_val      (st_val),
    .ready       (ready),
    .mem_rd_data (mem_rd_data),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tiny SRAM: only the low 4 address bits decode.
  assign sram_dq_in = sram_mem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[3:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [31:0] exp_rd);
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);
    check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
    check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("idle_addr", {14'd0, sram_addr}, 32'd0);
    check("idle_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("idle_rd_data", mem_rd_data, exp_rd);
  endtask

  // Starts in IDLE just after a posedge; returns just after the edge into IDLE
  // with the enables still asserted, as a frozen pipeline would leave them.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [17:0] exp_lo,
                        input logic [31:0] exp_rd);
    mem_r_en = r;
    mem_w_en = w;
    alu_res  = a;
    st_val   = d;
    @(negedge clk);
    check("req_ready", {31'd0, ready}, 32'd0);
    next_cyc();
    // Scramble data inputs: the controller must ignore them outside IDLE.
    alu_res = 32'h5A5A_5A5A;
    st_val  = 32'hA5A5_A5A5;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < W; c++) begin
        @(negedge clk);
        check("ph_ready", {31'd0, ready}, 32'd0);
        check("ph_addr", {14'd0, sram_addr}, {14'd0, exp_lo + 18'(ph)});
        check("ph_oe", {31'd0, sram_dq_oe}, {31'd0, w});
        check("ph_we_n", {31'd0, sram_we_n}, (w && c != W - 1) ? 32'd0 : 32'd1);
        if (w) check("ph_dq_out", {16'd0, sram_dq_out}, (ph == 0) ? {16'd0, d[15:0]} : {16'd0, d[31:16]});
        next_cyc();
      end
    end
    @(negedge clk);
    check("done_ready", {31'd0, ready}, 32'd1);
    check("done_rd_data", mem_rd_data, exp_rd);
    check("done_oe", {31'd0, sram_dq_oe}, 32'd0);
    next_cyc();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) sram_mem[i] = 16'h0000;

    // Reset held with requests asserted.
    rst      = 1'b0;
    mem_r_en = 1'b1;
    mem_w_en = 1'b1;
    alu_res  = 32'd1028;
    st_val   = 32'h1111_2222;
    repeat (3) next_cyc();
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    check_idle(32'd0);
    next_cyc();

    // Store then idle: the held request must not relaunch after DONE.
    access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 18'd2, 32'd0);
    mem_w_en = 1'b0;
    check_idle(32'd0);
    check("sram_lo", {16'd0, sram_mem[2]}, 32'h0000_BEEF);
    check("sram_hi", {16'd0, sram_mem[3]}, 32'h0000_DEAD);
    next_cyc();

    // Load back, then back-to-back load at an unaligned address of the same word.
    access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1031, 32'd0, 18'd2, 32'hDEAD_BEEF);

    // Both enables: write to the wrapped address 0 -> word 0x1FF00.
    access(1'b1, 1'b1, 32'd0, 32'h1234_5678, 18'h3FE00, 32'hDEAD_BEEF);
    // Back-to-back read of the same location.
    access(1'b1, 1'b0, 32'd0, 32'd0, 18'h3FE00, 32'h1234_5678);
    mem_r_en = 1'b0;
    check_idle(32'h1234_5678);
    next_cyc();

    // Abort a load with reset in the second HI cycle.
    mem_r_en = 1'b1;
    alu_res  = 32'd1028;
    next_cyc();              // -> LO0
    next_cyc();              // -> LO1
    next_cyc();              // -> HI0
    next_cyc();              // -> HI1
    rst = 1'b0;
    next_cyc();
    rst      = 1'b1;
    mem_r_en = 1'b0;
    check_idle(32'd0);
    next_cyc();

    // Subsequent load completes normally.
    access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEAD_BEEF);
    mem_r_en = 1'b0;
    check_idle(32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
